// File: rtl/video_timing_pkg.sv
// Purpose: shared timing constants, pixel type and window helper for the arcade video path.
// Latency: n/a (declarations only).
// Backpressure: n/a; every consumer of these timings runs free, with no flow control.
//
// Contents:
//   DEF_*      default 15 kHz raster timing (pixel clocks / lines)
//   CNT_W      raster counter width; every timing value must fit below 2**CNT_W
//   RGB_W      bits per colour channel
//   rgb_t      packed {r,g,b} pixel shared with the renderer and the scandoubler
//   in_window  start <= pos < start+len, evaluated without truncating start+len
package video_timing_pkg;

  localparam int CNT_W            = 9;
  localparam int RGB_W            = 4;

  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_H_TOTAL      = 384;
  localparam int DEF_H_ACTIVE     = 288;
  localparam int DEF_H_SYNC_START = 304;
  localparam int DEF_H_SYNC_LEN   = 32;
  localparam int DEF_V_TOTAL      = 264;
  localparam int DEF_V_ACTIVE     = 224;
  localparam int DEF_V_SYNC_START = 240;
  localparam int DEF_V_SYNC_LEN   = 8;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  // The counter is widened to int before comparing, so start+len may exceed
  // the counter range without wrapping into a false match.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input int start, input int len);
    int p;
    p = int'(pos);
    return (p >= start) && (p < start + len);
  endfunction

endpackage

// File: rtl/pixel_ce_div.sv
// Purpose: divide clk_sys into a one-cycle clock-enable pulse every DIV cycles.
// Latency: first ce pulse DIV cycles after reset release, then every DIV cycles.
// Backpressure: none; free-running.
//
// Ports:
//   clk_sys  system clock, posedge
//   reset_n  asynchronous active-low reset
//   ce       registered enable, high for one clk_sys cycle out of DIV
//
// Reusable for the audio and CPU clock enables as well as the pixel enable.
module pixel_ce_div #(
  parameter int DIV = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic ce
);

  localparam int           W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div;
  logic         at_last;

  assign at_last = (div == LAST);

  // ce is registered from the terminal count so it never glitches; this
  // also places the first pulse exactly DIV cycles after reset release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      ce  <= 1'b0;
    end else begin
      ce  <= at_last;
      div <= at_last ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Purpose: pixel enable, raster counters, syncs and blanked RGB output register.
// Latency: hcnt/vcnt one clk_sys after en_vid; syncs/RGB one pixel behind hcnt/vcnt.
// Backpressure: none; the raster runs free and the renderer must settle rgb_in within CLK_DIV-1 clocks.
//
// Ports:
//   clk_sys, reset_n          clock (posedge) and asynchronous active-low reset
//   rgb_in[11:0]              {r,g,b} for the position presented on the previous pixel
//   en_vid                    pixel enable, one clk_sys pulse per CLK_DIV
//   hcnt[8:0], vcnt[8:0]      current raster position
//   hblank, vblank            combinational blanking of the current position
//   frame_start               pulse with the en_vid that wraps the raster to (0,0)
//   hs_n, vs_n                registered active-low syncs
//   r_out, g_out, b_out       registered, blanked pixel
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [11:0] rgb_in,
  output logic        en_vid,
  output logic [8:0]  hcnt,
  output logic [8:0]  vcnt,
  output logic        hblank,
  output logic        vblank,
  output logic        frame_start,
  output logic        hs_n,
  output logic        vs_n,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out
);

  localparam int CNT_MAX = 1 << CNT_W;

  // Elaboration-time guards: a divider below 2 cannot produce a pulse and
  // timing values must be representable in the raster counters.
  if (CLK_DIV < 2) begin : g_bad_div
    $error("video_timing_gen: CLK_DIV must be at least 2");
  end
  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX ||
      H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL out of counter range");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic h_last;
  logic v_last;
  logic hs_raw;
  logic vs_raw;
  logic visible;
  rgb_t pix_in;
  rgb_t pix_q;

  // ---------------------------------------------------------------------
  // Pixel enable
  // ---------------------------------------------------------------------
  pixel_ce_div #(
    .DIV (CLK_DIV)
  ) u_pixel_ce_div (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (en_vid)
  );

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (en_vid) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // en_vid is registered and reset, so this pulse is clean and drops to 0
  // during reset without needing its own flop.
  assign frame_start = en_vid & h_last & v_last;

  // ---------------------------------------------------------------------
  // Decode of the current position (full-width unsigned compares)
  // ---------------------------------------------------------------------
  assign hblank  = (int'(hcnt) >= H_ACTIVE);
  assign vblank  = (int'(vcnt) >= V_ACTIVE);
  assign visible = !hblank && !vblank;

  // vcnt only moves at the hcnt wrap, so vs_raw is line-aligned by
  // construction and vs_n cannot toggle mid-line.
  assign hs_raw = in_window(hcnt, H_SYNC_START, H_SYNC_LEN);
  assign vs_raw = in_window(vcnt, V_SYNC_START, V_SYNC_LEN);

  // ---------------------------------------------------------------------
  // Output register: captures the decode of the position being left, so
  // syncs and pixel share the same one-pixel delay behind hcnt/vcnt.
  // ---------------------------------------------------------------------
  assign pix_in = rgb_t'(rgb_in);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_n  <= 1'b1;
      vs_n  <= 1'b1;
      pix_q <= '0;
    end else if (en_vid) begin
      hs_n  <= ~hs_raw;
      vs_n  <= ~vs_raw;
      pix_q <= visible ? pix_in : '0;
    end
  end

  assign r_out = pix_q.r;
  assign g_out = pix_q.g;
  assign b_out = pix_q.b;

endmodule

// File: tb/tb_video_timing_gen.sv
// Purpose: self-checking bench for video_timing_gen (reduced raster for full frames, default raster for line timing).
// Latency: n/a.
// Backpressure: n/a.
module tb_video_timing_gen;

  // Reduced raster: hcnt still spans bit 8 (blanking from 256) so full-width
  // compares are exercised, while a frame fits in 24000 clocks.
  localparam int D     = 4;
  localparam int HT    = 300;
  localparam int HA    = 256;
  localparam int HSS   = 264;
  localparam int HSL   = 16;
  localparam int VT    = 20;
  localparam int VA    = 12;
  localparam int VSS   = 14;
  localparam int VSL   = 3;
  localparam int FRAME = HT * VT;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] rgb_in  = '0;

  logic       s_en_vid, s_hblank, s_vblank, s_fs, s_hs_n, s_vs_n;
  logic [8:0] s_hcnt, s_vcnt;
  logic [3:0] s_r, s_g, s_b;

  logic       d_en_vid, d_hblank, d_vblank, d_fs, d_hs_n, d_vs_n;
  logic [8:0] d_hcnt, d_vcnt;
  logic [3:0] d_r, d_g, d_b;

  video_timing_gen #(
    .CLK_DIV (D), .H_TOTAL (HT), .H_ACTIVE (HA), .H_SYNC_START (HSS), .H_SYNC_LEN (HSL),
    .V_TOTAL (VT), .V_ACTIVE (VA), .V_SYNC_START (VSS), .V_SYNC_LEN (VSL)
  ) u_dut (
    .clk_sys (clk_sys), .reset_n (reset_n), .rgb_in (rgb_in),
    .en_vid (s_en_vid), .hcnt (s_hcnt), .vcnt (s_vcnt),
    .hblank (s_hblank), .vblank (s_vblank), .frame_start (s_fs),
    .hs_n (s_hs_n), .vs_n (s_vs_n), .r_out (s_r), .g_out (s_g), .b_out (s_b)
  );

  video_timing_gen u_def (
    .clk_sys (clk_sys), .reset_n (reset_n), .rgb_in (rgb_in),
    .en_vid (d_en_vid), .hcnt (d_hcnt), .vcnt (d_vcnt),
    .hblank (d_hblank), .vblank (d_vblank), .frame_start (d_fs),
    .hs_n (d_hs_n), .vs_n (d_vs_n), .r_out (d_r), .g_out (d_g), .b_out (d_b)
  );

  always #5 clk_sys = ~clk_sys;

  // Clock edges seen since the last reset release; the model is a pure
  // function of this count.
  int k;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)", name, act, exp, $time, k);
    end
  endtask

  // Pixels advanced after k edges: first en_vid sits after edge D, and the
  // counters move on the edge that follows each en_vid.
  function automatic int adv(input int kk);
    return (kk == 0) ? 0 : (kk - 1) / D;
  endfunction

  // Renderer stand-in: colour is a function of the absolute pixel index;
  // odd frames are solid white for the blanking count.
  function automatic logic [11:0] pat(input int n);
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    if (((n / FRAME) % 2) == 1) return 12'hFFF;
    return 12'((h * 7 + v * 131 + 1) % 4096);
  endfunction

  // Event records (-1 = not yet seen)
  int s_hs_fk = -1, s_hs_fh = -1, s_hs_w = -1;
  int s_vs_fk = -1, s_vs_fh = -1, s_vs_fv = -1, s_vs_w = -1;
  int s_fs1 = -1, s_fs2 = -1;
  int fff_cnt = 0, zero_cnt = 0;
  int d_en1 = -1, d_hs_fk = -1, d_hs_fh = -1, d_hs_fk2 = -1, d_hs_w = -1;
  logic p_s_hs = 1'b1, p_s_vs = 1'b1, p_d_hs = 1'b1;

  // Per-cycle comparison against the model, event capture, rgb_in drive.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (chk_on) begin
        int n, p, hp, vp, e_hs, e_vs, e_rgb, e_en;
        n    = adv(k);
        p    = n - 1;
        e_en = (k > 0 && (k % D) == 0) ? 1 : 0;
        chk("en_vid", s_en_vid, e_en);
        chk("hcnt", s_hcnt, n % HT);
        chk("vcnt", s_vcnt, (n / HT) % VT);
        chk("hblank", s_hblank, ((n % HT) >= HA) ? 1 : 0);
        chk("vblank", s_vblank, (((n / HT) % VT) >= VA) ? 1 : 0);
        chk("frame_start", s_fs,
            (e_en == 1 && (n % HT) == HT - 1 && ((n / HT) % VT) == VT - 1) ? 1 : 0);
        if (n == 0) begin
          e_hs = 1; e_vs = 1; e_rgb = 0;
        end else begin
          hp    = p % HT;
          vp    = (p / HT) % VT;
          e_hs  = (hp >= HSS && hp < HSS + HSL) ? 0 : 1;
          e_vs  = (vp >= VSS && vp < VSS + VSL) ? 0 : 1;
          e_rgb = (hp < HA && vp < VA) ? int'(pat(p)) : 0;
        end
        chk("hs_n", s_hs_n, e_hs);
        chk("vs_n", s_vs_n, e_vs);
        chk("rgb", {s_r, s_g, s_b}, e_rgb);
        chk("def_en_vid", d_en_vid, e_en);
        chk("def_hcnt", d_hcnt, n % 384);

        // Blanking census over the all-white frame
        if (s_en_vid && n >= 1 && (p / FRAME) == 1) begin
          if ({s_r, s_g, s_b} == 12'hFFF) fff_cnt++;
          if ({s_r, s_g, s_b} == 12'h000) zero_cnt++;
        end
        if (s_fs) begin
          if (s_fs1 < 0) s_fs1 = k;
          else if (s_fs2 < 0) s_fs2 = k;
        end
        if (p_s_hs && !s_hs_n && s_hs_fk < 0) begin s_hs_fk = k; s_hs_fh = s_hcnt; end
        if (!p_s_hs && s_hs_n && s_hs_fk >= 0 && s_hs_w < 0) s_hs_w = k - s_hs_fk;
        if (p_s_vs && !s_vs_n && s_vs_fk < 0) begin
          s_vs_fk = k; s_vs_fh = s_hcnt; s_vs_fv = s_vcnt;
        end
        if (!p_s_vs && s_vs_n && s_vs_fk >= 0 && s_vs_w < 0) s_vs_w = k - s_vs_fk;
        if (d_en_vid && d_en1 < 0) d_en1 = k;
        if (p_d_hs && !d_hs_n) begin
          if (d_hs_fk < 0) begin d_hs_fk = k; d_hs_fh = d_hcnt; end
          else if (d_hs_fk2 < 0) d_hs_fk2 = k;
        end
        if (!p_d_hs && d_hs_n && d_hs_fk >= 0 && d_hs_w < 0) d_hs_w = k - d_hs_fk;
        p_s_hs = s_hs_n;
        p_s_vs = s_vs_n;
        p_d_hs = d_hs_n;
        rgb_in = pat(n);
      end
    end
  end

  initial begin
    bit found;
    reset_n = 1'b0;
    chk_on  = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (49000) @(negedge clk_sys);

    // Hand-computed pins for the reduced raster
    chk("hs_fall_hcnt", s_hs_fh, 265);
    chk("hs_fall_clk", s_hs_fk, 1061);
    chk("hs_low_clks", s_hs_w, 64);
    chk("vs_fall_clk", s_vs_fk, 16805);
    chk("vs_fall_hcnt", s_vs_fh, 1);
    chk("vs_fall_vcnt", s_vs_fv, 14);
    chk("vs_low_clks", s_vs_w, 3600);
    chk("frame_start_first", s_fs1, 24000);
    chk("frame_start_period", s_fs2 - s_fs1, 24000);
    chk("white_pixels", fff_cnt, 3072);
    chk("black_pixels", zero_cnt, 2928);
    // Hand-computed pins for the default raster
    chk("def_first_en_vid", d_en1, 4);
    chk("def_hs_fall_hcnt", d_hs_fh, 305);
    chk("def_hs_fall_clk", d_hs_fk, 1221);
    chk("def_hs_low_clks", d_hs_w, 128);
    chk("def_line_period", d_hs_fk2 - d_hs_fk, 1536);

    // Mid-line, mid-frame reset while both syncs are low
    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(posedge clk_sys);
      #2;
      if (s_hcnt == 9'd270 && s_vcnt == 9'd15) found = 1'b1;
    end
    chk("reach_mid_position", found, 1);
    chk("pre_reset_hs_n", s_hs_n, 0);
    chk("pre_reset_vs_n", s_vs_n, 0);
    reset_n = 1'b0;
    #1;
    chk("async_hcnt", s_hcnt, 0);
    chk("async_vcnt", s_vcnt, 0);
    chk("async_en_vid", s_en_vid, 0);
    chk("async_frame_start", s_fs, 0);
    chk("async_hs_n", s_hs_n, 1);
    chk("async_vs_n", s_vs_n, 1);
    chk("async_rgb", {s_r, s_g, s_b}, 0);
    chk("async_def_hcnt", d_hcnt, 0);
    chk("async_def_hs_n", d_hs_n, 1);
    s_hs_fk = -1; s_hs_fh = -1; s_hs_w = -1;
    d_hs_fk = -1; d_hs_fh = -1; d_hs_fk2 = -1; d_hs_w = -1;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3200) @(negedge clk_sys);
    chk("restart_hs_fall_clk", s_hs_fk, 1061);
    chk("restart_def_hs_fall_hcnt", d_hs_fh, 305);
    chk("restart_def_hs_fall_clk", d_hs_fk, 1221);
    chk("restart_def_line_period", d_hs_fk2 - d_hs_fk, 1536);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
